// File: rtl/sgmii_tx_gearbox.sv
// 10:4 transmit gearbox: 8b/10b symbols in, 4 line bits per 312.5 MHz clock out, MSB first.
// Optional GEARBOX_PRBS_EN adds a prbs_en input that replaces line data with PRBS-7.
module sgmii_tx_gearbox #(
    parameter bit INVERT = 1'b0
) (
    input  logic        clk_312p5mhz,
    input  logic        rst,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [9:0]  sym_data,
    output logic [3:0]  tx_data,
    output logic        tx_underflow
`ifdef GEARBOX_PRBS_EN
    ,
    input  logic        prbs_en
`endif
);

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BUF_W  = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned LFSR_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [NIB_W-1:0] IDLE_NIB = {NIB_W{INVERT}};

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d, buf_base;
    logic [CNT_W-1:0]   count_q, count_d, post;
    logic [NIB_W-1:0]   tx_d;
    logic               underflow_d;
    logic               accept, drain, starve;
    logic [BUF_W-1:0]   sym_aligned;

`ifdef GEARBOX_PRBS_EN
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d, lfsr_t;
    logic [NIB_W-1:0]   prbs_nib;
    logic               fb;
`endif

    // Ready depends only on registered occupancy so upstream sees no comb path from sym_valid.
`ifdef GEARBOX_PRBS_EN
    assign sym_ready = (count_q <= CNT_W'(SYM_W)) && !prbs_en;
`else
    assign sym_ready = (count_q <= CNT_W'(SYM_W));
`endif

    assign accept      = sym_valid && sym_ready;
    assign drain       = (state_q == RUN) && (count_q >= CNT_W'(NIB_W));
    assign starve      = (state_q == RUN) && (count_q <  CNT_W'(NIB_W));
    assign sym_aligned = {sym_data, {(BUF_W-SYM_W){1'b0}}};

    // Next-state, buffer and line output.
    always_comb begin
        state_d     = state_q;
        buf_base    = buf_q;
        post        = count_q;
        tx_d        = IDLE_NIB;
        underflow_d = 1'b0;
`ifdef GEARBOX_PRBS_EN
        lfsr_d      = lfsr_q;
        lfsr_t      = lfsr_q;
        prbs_nib    = '0;
        fb          = 1'b0;
`endif

        if (drain) begin
            tx_d     = buf_q[BUF_W-1 -: NIB_W] ^ IDLE_NIB;
            buf_base = {buf_q[BUF_W-NIB_W-1:0], {NIB_W{1'b0}}};
            post     = CNT_W'(count_q - CNT_W'(NIB_W));
        end else if (starve) begin
            // Residual bits shorter than a nibble are dropped.
            underflow_d = 1'b1;
            buf_base    = '0;
            post        = '0;
        end

        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (starve && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            buf_d   = buf_base | (sym_aligned >> post);
            count_d = CNT_W'(post + CNT_W'(SYM_W));
        end else begin
            buf_d   = buf_base;
            count_d = post;
        end

`ifdef GEARBOX_PRBS_EN
        // PRBS-7 (x^7+x^6+1), four bits per clock, oldest bit first.
        if (prbs_en) begin
            for (int i = 0; i < int'(NIB_W); i++) begin
                fb                    = lfsr_t[LFSR_W-1] ^ lfsr_t[LFSR_W-2];
                prbs_nib[NIB_W-1-i]   = fb;
                lfsr_t                = {lfsr_t[LFSR_W-2:0], fb};
            end
            lfsr_d      = lfsr_t;
            tx_d        = prbs_nib ^ IDLE_NIB;
            state_d     = IDLE;
            buf_d       = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_312p5mhz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            count_q      <= '0;
            tx_data      <= IDLE_NIB;
            tx_underflow <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            tx_data      <= tx_d;
            tx_underflow <= underflow_d;
        end
    end

`ifdef GEARBOX_PRBS_EN
    always_ff @(posedge clk_312p5mhz or posedge rst) begin
        if (rst) lfsr_q <= {LFSR_W{1'b1}};
        else     lfsr_q <= lfsr_d;
    end
`endif

endmodule

// File: tb/tb_sgmii_tx_gearbox.sv
// Directed bench for sgmii_tx_gearbox; a normal and an INVERT=1 instance run side by side.
module tb_sgmii_tx_gearbox;

    localparam logic [9:0] K_NEG = 10'b1100000101;
    localparam logic [9:0] K_POS = 10'b0011111010;

    logic       clk_312p5mhz = 1'b0;
    logic       rst;
    logic       sym_valid;
    logic [9:0] sym_data;
    logic       sym_ready, sym_ready_i;
    logic [3:0] tx_data, tx_data_i;
    logic       tx_underflow, tx_underflow_i;
`ifdef GEARBOX_PRBS_EN
    logic       prbs_en;
`endif

    int         nvec = 0;
    int         nmis = 0;
    logic       bitq[$];
    logic [4:0] rdy_pat = 5'b01001;
    logic [3:0] nib;
    logic       exp_r;
    logic       sel;

    always #2 clk_312p5mhz = ~clk_312p5mhz;

    sgmii_tx_gearbox #(.INVERT(1'b0)) dut (
        .clk_312p5mhz (clk_312p5mhz),
        .rst          (rst),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_data     (sym_data),
        .tx_data      (tx_data),
        .tx_underflow (tx_underflow)
`ifdef GEARBOX_PRBS_EN
        ,
        .prbs_en      (prbs_en)
`endif
    );

    sgmii_tx_gearbox #(.INVERT(1'b1)) dut_inv (
        .clk_312p5mhz (clk_312p5mhz),
        .rst          (rst),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready_i),
        .sym_data     (sym_data),
        .tx_data      (tx_data_i),
        .tx_underflow (tx_underflow_i)
`ifdef GEARBOX_PRBS_EN
        ,
        .prbs_en      (prbs_en)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp_tx, input logic exp_uf);
        chk({tag, ".tx"},     tx_data,                 exp_tx);
        chk({tag, ".tx_inv"}, tx_data_i,               ~exp_tx);
        chk({tag, ".uf"},     4'({3'b0, tx_underflow}),   4'({3'b0, exp_uf}));
        chk({tag, ".uf_inv"}, 4'({3'b0, tx_underflow_i}), 4'({3'b0, exp_uf}));
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        chk({tag, ".rdy"},     4'({3'b0, sym_ready}),   4'({3'b0, exp}));
        chk({tag, ".rdy_inv"}, 4'({3'b0, sym_ready_i}), 4'({3'b0, exp}));
    endtask

    task automatic tick;
        @(posedge clk_312p5mhz);
        #1;
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int b = 9; b >= 0; b--) bitq.push_back(s[b]);
    endtask

    task automatic pop_nib(output logic [3:0] n);
        for (int k = 0; k < 4; k++) begin
            if (bitq.size() > 0) n[3-k] = bitq.pop_front();
            else                 n[3-k] = 1'bx;
        end
    endtask

    initial begin
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_data  = '0;
        sel       = 1'b0;
`ifdef GEARBOX_PRBS_EN
        prbs_en   = 1'b0;
`endif
        repeat (3) @(posedge clk_312p5mhz);
        #1;
        chk_out("reset", 4'b0000, 1'b0);
        chk_rdy("reset", 1'b1);
        rst = 1'b0;

        // Idle line after reset release
        for (int i = 0; i < 20; i++) begin
            tick;
            chk_out("idle", 4'b0000, 1'b0);
            chk_rdy("idle", 1'b1);
        end

        // Single symbol: two nibbles, then underflow drops the last two bits
        sym_valid = 1'b1;
        sym_data  = K_NEG;
        tick;
        sym_valid = 1'b0;
        chk_out("single_n1", 4'b0000, 1'b0);
        tick; chk_out("single_n2", 4'b1100, 1'b0);
        tick; chk_out("single_n3", 4'b0001, 1'b0);
        tick; chk_out("single_uf", 4'b0000, 1'b1);
        tick; chk_out("single_idle", 4'b0000, 1'b0);
        chk_rdy("single_idle", 1'b1);

        // Continuous alternating stream; ready follows a 5-cycle pattern
        for (int i = 0; i <= 40; i++) begin
            sym_valid = 1'b1;
            sym_data  = sel ? K_POS : K_NEG;
            exp_r     = (i == 0) ? 1'b1 : rdy_pat[(i-1) % 5];
            chk_rdy("stream", exp_r);
            if (exp_r) begin
                push_sym(sym_data);
                sel = ~sel;
            end
            tick;
            if (i >= 1) begin
                pop_nib(nib);
                chk_out("stream", nib, 1'b0);
            end
        end

        // Upstream stall: remaining nibbles, one underflow pulse, two bits dropped
        sym_valid = 1'b0;
        tick; pop_nib(nib); chk_out("stall_a", nib, 1'b0);
        tick; pop_nib(nib); chk_out("stall_b", nib, 1'b0);
        tick; chk_out("stall_uf", 4'b0000, 1'b1);
        tick; chk_out("stall_post", 4'b0000, 1'b0);
        chk_rdy("stall_post", 1'b1);
        tick; chk_out("stall_post2", 4'b0000, 1'b0);
        bitq.delete();

        // Clean restart with two-cycle latency
        sym_valid = 1'b1;
        sym_data  = K_POS;
        tick;
        sym_valid = 1'b0;
        chk_out("restart_n1", 4'b0000, 1'b0);
        tick; chk_out("restart_n2", 4'b0011, 1'b0);
        tick; chk_out("restart_n3", 4'b1110, 1'b0);
        tick; chk_out("restart_uf", 4'b0000, 1'b1);
        tick;

        // Fill to 14 bits, then async reset mid-cycle
        sym_valid = 1'b1;
        sym_data  = K_NEG;
        repeat (5) tick;
        sym_valid = 1'b0;
        chk_rdy("pre_rst", 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_out("async_rst", 4'b0000, 1'b0);
        chk_rdy("async_rst", 1'b1);
        @(posedge clk_312p5mhz);
        #1 rst = 1'b0;
        sym_valid = 1'b1;
        sym_data  = K_POS;
        tick;
        sym_valid = 1'b0;
        chk_out("post_rst_n1", 4'b0000, 1'b0);
        tick; chk_out("post_rst_n2", 4'b0011, 1'b0);
        tick; chk_out("post_rst_n3", 4'b1110, 1'b0);
        tick; chk_out("post_rst_uf", 4'b0000, 1'b1);
        tick; chk_out("post_rst_idle", 4'b0000, 1'b0);

`ifdef GEARBOX_PRBS_EN
        // PRBS-7 from the all-ones seed: b[n] = b[n-7] ^ b[n-6]
        rst = 1'b1;
        @(posedge clk_312p5mhz);
        #1 rst = 1'b0;
        for (int k = 0; k < 7; k++) bitq.push_back(1'b1);
        prbs_en   = 1'b1;
        sym_valid = 1'b1;
        sym_data  = K_NEG;
        for (int i = 0; i < 8; i++) begin
            chk_rdy("prbs", 1'b0);
            for (int k = 0; k < 4; k++) begin
                bitq.push_back(bitq[bitq.size()-7] ^ bitq[bitq.size()-6]);
                nib[3-k] = bitq[bitq.size()-1];
            end
            tick;
            chk_out("prbs", nib, 1'b0);
        end
        prbs_en   = 1'b0;
        sym_valid = 1'b0;
        bitq.delete();
        tick;
        chk_out("prbs_exit", 4'b0000, 1'b0);
        chk_rdy("prbs_exit", 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
